serial_frame_receiver: RTL and testbench

- Multi-lane serial-to-parallel receiver; successor to the single-lane enable-gated shift register.
- Shifts NCH serial lanes in parallel, counts bits, and on every WIDTH-th accepted bit transfers the frame into a holding register.
- The holding register is offered downstream through a valid/ready handshake.
- Adds a selectable bit order, a mid-frame abort and a sticky overflow flag. Sits between the serial front-end and the frame-parsing logic.

---
 rtl/serial_frame_receiver.sv | 85 ++++++++
 tb/tb_serial_frame_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver
// Description : Multi-lane serial-to-parallel frame receiver with a
//               valid/ready holding register, abort and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver #(
    parameter int  WIDTH     = 16,
    parameter int  NCH       = 2,
    parameter int  MSB_FIRST = 1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 enable,
    input  logic [NCH-1:0]       signal_in,
    input  logic                 frame_abort,
    input  logic                 clr_ovf,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        bit_cnt,
    output logic                 overflow
);

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [NCH*WIDTH-1:0] r_sr;
    logic [NCH*WIDTH-1:0] w_sr_next;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_load;
    logic                 w_drop;

    // Next shift-register image; on a completion edge this is the full frame
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign w_sr_next[c*WIDTH +: WIDTH] =
                {r_sr[c*WIDTH +: WIDTH-1], signal_in[c]};
        end else begin : g_lsb
            assign w_sr_next[c*WIDTH +: WIDTH] =
                {signal_in[c], r_sr[c*WIDTH+1 +: WIDTH-1]};
        end
    end

    assign w_accept   = enable & ~frame_abort;
    assign w_complete = w_accept & (bit_cnt == c_last_bit);
    assign w_load     = w_complete & (~out_valid | out_ready);
    assign w_drop     = w_complete & out_valid & ~out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sr      <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_abort) begin
                r_sr    <= '0;
                bit_cnt <= '0;
            end else if (enable) begin
                r_sr    <= w_sr_next;
                bit_cnt <= w_complete ? '0 : bit_cnt + CW'(1);
            end

            if (w_load) begin
                out_data  <= w_sr_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A dropped frame outranks a simultaneous clear
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_receiver
// Description : Self-checking bench; MSB-first and LSB-first instances share
//               stimulus and are compared to a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int CW = $clog2(W + 1);

    logic           CLK         = 1'b0;
    logic           RST_N       = 1'b0;
    logic           enable      = 1'b0;
    logic [N-1:0]   signal_in   = '0;
    logic           frame_abort = 1'b0;
    logic           clr_ovf     = 1'b0;
    logic           out_ready   = 1'b0;

    logic [N*W-1:0] dm_data, dl_data;
    logic           dm_valid, dl_valid, dm_ovf, dl_ovf;
    logic [CW-1:0]  dm_cnt, dl_cnt;

    always #5 CLK = ~CLK;

    serial_frame_receiver #(.WIDTH(W), .NCH(N), .MSB_FIRST(1)) dut_msb (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .signal_in(signal_in),
        .frame_abort(frame_abort), .clr_ovf(clr_ovf), .out_data(dm_data),
        .out_valid(dm_valid), .out_ready(out_ready), .bit_cnt(dm_cnt),
        .overflow(dm_ovf)
    );

    serial_frame_receiver #(.WIDTH(W), .NCH(N), .MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .signal_in(signal_in),
        .frame_abort(frame_abort), .clr_ovf(clr_ovf), .out_data(dl_data),
        .out_valid(dl_valid), .out_ready(out_ready), .bit_cnt(dl_cnt),
        .overflow(dl_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-lane accumulated values built arithmetically
    int m_cnt;
    int acc_m [N];
    int acc_l [N];
    int m_dm, m_dl;
    bit m_valid, m_ovf;

    typedef struct {
        bit         en;
        bit [N-1:0] sig;
        bit         rdy;
        bit [3:0]   cnt;
        bit         vld;
        bit [15:0]  dm;
        bit [15:0]  dl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_dm = 0; m_dl = 0; m_valid = 0; m_ovf = 0;
        for (int c = 0; c < N; c++) begin
            acc_m[c] = 0;
            acc_l[c] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit [N-1:0] sig, input bit ab,
                              input bit clr, input bit rdy);
        bit comp = 0;
        int fm = 0;
        int fl = 0;
        if (ab) begin
            m_cnt = 0;
            for (int c = 0; c < N; c++) begin acc_m[c] = 0; acc_l[c] = 0; end
        end else if (en) begin
            for (int c = 0; c < N; c++) begin
                acc_m[c] = (acc_m[c] * 2 + int'(sig[c])) % (1 << W);
                acc_l[c] = acc_l[c] + (int'(sig[c]) << m_cnt);
            end
            if (m_cnt == W - 1) begin
                comp = 1;
                for (int c = 0; c < N; c++) begin
                    fm += acc_m[c] << (c * W);
                    fl += acc_l[c] << (c * W);
                    acc_m[c] = 0;
                    acc_l[c] = 0;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (comp && m_valid && !rdy) m_ovf = 1;
        else if (clr)                m_ovf = 0;
        if (comp && (!m_valid || rdy)) begin
            m_dm = fm; m_dl = fl; m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit en, input bit [N-1:0] sig, input bit ab,
                        input bit clr, input bit rdy);
        enable = en; signal_in = sig; frame_abort = ab; clr_ovf = clr; out_ready = rdy;
        @(posedge CLK);
        model_edge(en, sig, ab, clr, rdy);
        #1;
    endtask

    task automatic send_bits(input bit [7:0] l0, input bit [7:0] l1, input int from,
                             input int to, input bit rdy_last, input bit clr_last);
        for (int i = from; i <= to; i++)
            step(1'b1, {l1[7-i], l0[7-i]}, 1'b0, (i == 7) && clr_last, (i == 7) && rdy_last);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " cnt_msb"},   32'(dm_cnt),   m_cnt);
        chk({tag, " cnt_lsb"},   32'(dl_cnt),   m_cnt);
        chk({tag, " valid_msb"}, 32'(dm_valid), 32'(m_valid));
        chk({tag, " valid_lsb"}, 32'(dl_valid), 32'(m_valid));
        chk({tag, " ovf_msb"},   32'(dm_ovf),   32'(m_ovf));
        chk({tag, " ovf_lsb"},   32'(dl_ovf),   32'(m_ovf));
        chk({tag, " data_msb"},  32'(dm_data),  m_dm);
        chk({tag, " data_lsb"},  32'(dl_data),  m_dl);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " data_msb"}, 32'(dm_data),  0);
        chk({tag, " data_lsb"}, 32'(dl_data),  0);
        chk({tag, " valid"},    32'(dm_valid), 0);
        chk({tag, " cnt"},      32'(dm_cnt),   0);
        chk({tag, " ovf"},      32'(dm_ovf),   0);
    endtask

    initial begin
        vec_t       tbl [10];
        bit [7:0]   b0 = 8'hA5;
        bit [7:0]   b1 = 8'h3C;

        for (int i = 0; i < 8; i++) begin
            tbl[i].en  = 1'b1;
            tbl[i].sig = {b1[7-i], b0[7-i]};
            tbl[i].rdy = 1'b0;
            tbl[i].cnt = 4'((i + 1) % 8);
            tbl[i].vld = (i == 7);
            tbl[i].dm  = (i == 7) ? 16'h3CA5 : 16'h0000;
            tbl[i].dl  = (i == 7) ? 16'h3CA5 : 16'h0000;
        end
        tbl[8] = '{en: 1'b0, sig: 2'b00, rdy: 1'b0, cnt: 4'd0, vld: 1'b1, dm: 16'h3CA5, dl: 16'h3CA5};
        tbl[9] = '{en: 1'b0, sig: 2'b00, rdy: 1'b1, cnt: 4'd0, vld: 1'b0, dm: 16'h3CA5, dl: 16'h3CA5};

        // Reset held while inputs toggle
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1; signal_in = 2'($urandom); out_ready = 1'($urandom);
            clr_ovf = 1'($urandom);
            @(posedge CLK); #1;
            check_zero("reset_hold");
        end
        RST_N = 1'b1;

        // MSB-first frame 0x3CA5, held until out_ready
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].sig, 1'b0, 1'b0, tbl[i].rdy);
            chk($sformatf("vec%0d cnt_msb", i),  32'(dm_cnt),   32'(tbl[i].cnt));
            chk($sformatf("vec%0d cnt_lsb", i),  32'(dl_cnt),   32'(tbl[i].cnt));
            chk($sformatf("vec%0d valid", i),    32'(dm_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d ovf", i),      32'(dm_ovf),   0);
            chk($sformatf("vec%0d data_msb", i), 32'(dm_data),  32'(tbl[i].dm));
            chk($sformatf("vec%0d data_lsb", i), 32'(dl_data),  32'(tbl[i].dl));
        end

        // Gap of three idle cycles between bits 4 and 5
        send_bits(8'hA5, 8'h3C, 0, 3, 1'b0, 1'b0);
        chk("gap cnt_before", 32'(dm_cnt), 4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'($urandom), 1'b0, 1'b0, 1'b0);
            chk("gap cnt_msb", 32'(dm_cnt), 4);
            chk("gap cnt_lsb", 32'(dl_cnt), 4);
        end
        send_bits(8'hA5, 8'h3C, 4, 7, 1'b0, 1'b0);
        chk("gap valid",    32'(dl_valid), 1);
        chk("gap data_msb", 32'(dm_data),  32'h3CA5);
        chk("gap data_lsb", 32'(dl_data),  32'h3CA5);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("gap drained", 32'(dm_valid), 0);

        // Overflow, set-beats-clear, then clear
        send_bits(8'h34, 8'h12, 0, 7, 1'b0, 1'b0);
        chk("ovf first_data", 32'(dm_data), 32'h1234);
        send_bits(8'hEF, 8'hBE, 0, 7, 1'b0, 1'b0);
        chk("ovf data_kept", 32'(dm_data), 32'h1234);
        chk("ovf set",       32'(dm_ovf),  1);
        check_model("ovf");
        send_bits(8'h55, 8'h55, 0, 7, 1'b0, 1'b1);
        chk("ovf set_wins", 32'(dm_ovf), 1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("ovf cleared",    32'(dm_ovf),   0);
        chk("ovf valid_kept", 32'(dm_valid), 1);
        chk("ovf data_still", 32'(dm_data),  32'h1234);

        // Consume and reload on the same edge
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        send_bits(8'h11, 8'h11, 0, 7, 1'b0, 1'b0);
        send_bits(8'h22, 8'h22, 0, 7, 1'b1, 1'b0);
        chk("simul data",  32'(dm_data),  32'h2222);
        chk("simul valid", 32'(dm_valid), 1);
        chk("simul ovf",   32'(dm_ovf),   0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Abort at bit_cnt=6 with enable high, then a fresh frame
        send_bits(8'hFF, 8'hFF, 0, 5, 1'b0, 1'b0);
        chk("abort cnt_before", 32'(dm_cnt), 6);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        chk("abort cnt_msb", 32'(dm_cnt), 0);
        chk("abort cnt_lsb", 32'(dl_cnt), 0);
        chk("abort no_load", 32'(dm_valid), 0);
        send_bits(8'hFF, 8'h00, 0, 7, 1'b0, 1'b0);
        chk("abort data_msb", 32'(dm_data), 32'h00FF);
        chk("abort data_lsb", 32'(dl_data), 32'h00FF);
        check_model("abort");
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame with a held frame and overflow set
        send_bits(8'h11, 8'h11, 0, 7, 1'b0, 1'b0);
        send_bits(8'h22, 8'h22, 0, 7, 1'b0, 1'b0);
        send_bits(8'hFF, 8'hFF, 0, 4, 1'b0, 1'b0);
        check_model("pre_reset");
        #2;
        RST_N = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0));
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
